// File: rtl/axi_w_fifo_drain.sv
// Drains packed {WDATA, WSTRB, WLAST} words from the S_W async FIFO read side onto an AXI4 W channel.
// Beats are metered by queued AW burst lengths; WLAST is regenerated from the length and mismatches are flagged.
module axi_w_fifo_drain #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    localparam int STRB_W = DATA_W / 8,
    localparam int FW     = DATA_W + STRB_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FW-1:0]     fifo_rdata,
    input  logic              fifo_rempty,
    output logic              fifo_rpop,
    input  logic              aw_fire,
    input  logic [LEN_W-1:0]  aw_len,
    output logic              aw_room,
    output logic [DATA_W-1:0] WDATA_S,
    output logic [STRB_W-1:0] WSTRB_S,
    output logic              WLAST_S,
    output logic              WVALID_S,
    input  logic              WREADY_S,
    output logic              wlast_err
);

    logic [LEN_W-1:0] lq_mem [2];
    logic             lq_rd;
    logic             lq_wr;
    logic [1:0]       lq_cnt;

    logic [FW-1:0]    buf_mem [2];
    logic             buf_rd;
    logic             buf_wr;
    logic [1:0]       buf_cnt;

    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] lq_head;
    logic             is_last;
    logic             lq_push;
    logic             lq_pop;
    logic             accept;
    logic [FW-1:0]    buf_head;

    // Pop decision depends only on registered occupancy, never on WREADY_S.
    always_comb begin
        lq_head   = lq_mem[lq_rd];
        is_last   = (beat_cnt == lq_head);
        aw_room   = (lq_cnt != 2'd2);
        fifo_rpop = !fifo_rempty && (lq_cnt != 2'd0) && (buf_cnt != 2'd2);
        lq_push   = aw_fire && aw_room;
        lq_pop    = fifo_rpop && is_last;
        accept    = WVALID_S && WREADY_S;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lq_mem[0] <= '0;
            lq_mem[1] <= '0;
            lq_rd     <= 1'b0;
            lq_wr     <= 1'b0;
            lq_cnt    <= 2'd0;
        end else begin
            if (lq_push) begin
                lq_mem[lq_wr] <= aw_len;
                lq_wr         <= ~lq_wr;
            end
            if (lq_pop) begin
                lq_rd <= ~lq_rd;
            end
            case ({lq_push, lq_pop})
                2'b10:   lq_cnt <= lq_cnt + 2'd1;
                2'b01:   lq_cnt <= lq_cnt - 2'd1;
                default: lq_cnt <= lq_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            wlast_err <= 1'b0;
        end else begin
            wlast_err <= fifo_rpop && (fifo_rdata[0] != is_last);
            if (fifo_rpop) begin
                beat_cnt <= is_last ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    // Stored WLAST is the length-derived value, not the FIFO's bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            buf_rd     <= 1'b0;
            buf_wr     <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            if (fifo_rpop) begin
                buf_mem[buf_wr] <= {fifo_rdata[FW-1:1], is_last};
                buf_wr          <= ~buf_wr;
            end
            if (accept) begin
                buf_rd <= ~buf_rd;
            end
            case ({fifo_rpop, accept})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    always_comb begin
        buf_head = buf_mem[buf_rd];
        WDATA_S  = buf_head[FW-1:STRB_W+1];
        WSTRB_S  = buf_head[STRB_W:1];
        WLAST_S  = buf_head[0];
        WVALID_S = (buf_cnt != 2'd0);
    end

endmodule

// File: tb/tb_axi_w_fifo_drain.sv
// Bench for axi_w_fifo_drain: queue-based FIFO source, burst-pairing reference model and a W-channel scoreboard.
// Directed scenarios first, then randomized bursts with random WREADY backpressure and occasional bad WLAST bits.
module tb_axi_w_fifo_drain;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int STRB_W = DATA_W / 8;
    localparam int FW     = DATA_W + STRB_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [FW-1:0]     fifo_rdata;
    logic              fifo_rempty;
    logic              fifo_rpop;
    logic              aw_fire;
    logic [LEN_W-1:0]  aw_len;
    logic              aw_room;
    logic [DATA_W-1:0] WDATA_S;
    logic [STRB_W-1:0] WSTRB_S;
    logic              WLAST_S;
    logic              WVALID_S;
    logic              WREADY_S;
    logic              wlast_err;

    axi_w_fifo_drain #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rpop(fifo_rpop),
        .aw_fire(aw_fire), .aw_len(aw_len), .aw_room(aw_room),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S), .wlast_err(wlast_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: announced lengths and words, paired in order into expected beats.
    logic [FW-1:0] fq[$];
    logic [FW-1:0] words_q[$];
    int            lens_q[$];
    logic [FW-1:0] exp_q[$];
    int            pos = 0;
    int            exp_err = 0;
    int            err_seen = 0;
    logic          pop_d = 1'b0;
    logic          rand_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void build_expected();
        logic [FW-1:0] w;
        logic          last;
        while (lens_q.size() > 0 && words_q.size() > 0) begin
            w    = words_q.pop_front();
            last = (pos == lens_q[0]);
            if (w[0] != last) exp_err++;
            exp_q.push_back({w[FW-1:1], last});
            if (last) begin
                void'(lens_q.pop_front());
                pos = 0;
            end else begin
                pos++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic wl);
        logic [FW-1:0] w;
        w = {$urandom(), 4'($urandom_range(0, 15)), wl};
        fq.push_back(w);
        words_q.push_back(w);
        build_expected();
    endtask

    task automatic fire_aw(input int len, input bit model);
        aw_fire = 1'b1;
        aw_len  = LEN_W'(len);
        if (model) begin
            lens_q.push_back(len);
            build_expected();
        end
        tick();
        aw_fire = 1'b0;
    endtask

    task automatic send_aw(input int len);
        int t = 0;
        while (!aw_room && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) chk("aw_room_timeout", 64'(aw_room), 64'd1);
        fire_aw(len, 1'b1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            tick();
            t++;
        end
        tick();
        tick();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // FIFO source: pop seen at negedge is applied just after the edge, then outputs refresh.
    always @(negedge clk) pop_d = fifo_rpop && !rst;

    always @(posedge clk) begin
        #1;
        if (pop_d && fq.size() > 0) void'(fq.pop_front());
        pop_d = 1'b0;
        #1;
        fifo_rempty = (fq.size() == 0);
        fifo_rdata  = (fq.size() == 0) ? '0 : fq[0];
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) WREADY_S = ($urandom_range(0, 3) != 0);
    end

    // Monitor: scoreboard pop on each accepted beat, AXI payload stability, wlast_err pulse count.
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic [FW-1:0] prev_p = '0;

    always @(negedge clk) begin
        logic [FW-1:0] cur;
        logic [FW-1:0] e;
        cur = {WDATA_S, WSTRB_S, WLAST_S};
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (wlast_err) err_seen++;
            if (prev_v && !prev_r) begin
                chk("hold_valid", 64'(WVALID_S), 64'd1);
                chk("hold_payload", 64'(cur), 64'(prev_p));
            end
            if (WVALID_S && WREADY_S) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(cur), 64'd0);
                    if (cur == '0) chk("unexpected_beat_valid", 64'(WVALID_S), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'(cur), 64'(e));
                end
            end
            prev_v = WVALID_S;
            prev_r = WREADY_S;
            prev_p = cur;
        end
    end

    initial begin
        int pops;
        int bad;
        int vcnt;
        int err0;
        int exp0;
        int len;
        logic wl;
        rst = 1'b1;
        aw_fire = 1'b0;
        aw_len = '0;
        WREADY_S = 1'b1;
        fifo_rempty = 1'b1;
        fifo_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_rpop", 64'(fifo_rpop), 64'd0);
        chk("rst_wvalid", 64'(WVALID_S), 64'd0);
        chk("rst_wlast", 64'(WLAST_S), 64'd0);
        chk("rst_wdata", 64'(WDATA_S), 64'd0);
        chk("rst_wstrb", 64'(WSTRB_S), 64'd0);
        chk("rst_wlast_err", 64'(wlast_err), 64'd0);
        chk("rst_aw_room", 64'(aw_room), 64'd1);

        // Single 4-beat burst, full rate.
        for (int i = 0; i < 4; i++) push_word(i == 3);
        send_aw(3);
        chk("first_pop", 64'(fifo_rpop), 64'd1);
        tick();
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (WVALID_S) vcnt++;
            tick();
        end
        chk("burst_contiguous", 64'(vcnt), 64'd4);
        chk("burst_end_idle", 64'(WVALID_S), 64'd0);
        drain("drain_single");

        // Backpressure: 8-beat burst with WREADY low for 5 cycles.
        WREADY_S = 1'b0;
        for (int i = 0; i < 8; i++) push_word(i == 7);
        send_aw(7);
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            if (fifo_rpop) pops++;
            tick();
        end
        chk("stall_pops", 64'(pops), 64'd2);
        chk("stall_valid", 64'(WVALID_S), 64'd1);
        WREADY_S = 1'b1;
        drain("drain_backpressure");

        // Data present without any length: nothing moves.
        push_word(1'b1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (fifo_rpop || WVALID_S) bad++;
            tick();
        end
        chk("no_len_idle", 64'(bad), 64'd0);
        send_aw(0);
        drain("drain_len0");

        // WLAST mismatch on beat 2 of a 2-beat burst, followed by a clean single beat.
        err0 = err_seen;
        exp0 = exp_err;
        push_word(1'b0);
        push_word(1'b0);
        send_aw(1);
        push_word(1'b1);
        send_aw(0);
        drain("drain_mismatch");
        chk("mismatch_err_count", 64'(err_seen - err0), 64'(exp_err - exp0));

        // Length queue full, dropped third AW, and push coinciding with retire.
        fire_aw(0, 1'b1);
        fire_aw(0, 1'b1);
        chk("lq_full_room", 64'(aw_room), 64'd0);
        fire_aw(5, 1'b0);
        chk("lq_drop_room", 64'(aw_room), 64'd0);
        push_word(1'b1);
        push_word(1'b1);
        drain("drain_lq_full");
        push_word(1'b1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (fifo_rpop) bad++;
            tick();
        end
        chk("no_overpop", 64'(bad), 64'd0);
        fire_aw(0, 1'b1);
        chk("retire_cycle_pop", 64'(fifo_rpop), 64'd1);
        fire_aw(0, 1'b1);
        chk("push_retire_room", 64'(aw_room), 64'd1);
        fire_aw(0, 1'b1);
        chk("push_retire_cnt", 64'(aw_room), 64'd0);
        push_word(1'b1);
        push_word(1'b1);
        drain("drain_push_retire");

        // Asynchronous reset during beat 2 of a 4-beat burst.
        for (int i = 0; i < 4; i++) push_word(i == 3);
        send_aw(3);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_wvalid", 64'(WVALID_S), 64'd0);
        chk("mid_rst_wdata", 64'(WDATA_S), 64'd0);
        chk("mid_rst_aw_room", 64'(aw_room), 64'd1);
        chk("mid_rst_rpop", 64'(fifo_rpop), 64'd0);
        fq.delete();
        words_q.delete();
        lens_q.delete();
        exp_q.delete();
        pos = 0;
        fifo_rempty = 1'b1;
        fifo_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        push_word(1'b0);
        push_word(1'b1);
        send_aw(1);
        drain("drain_after_rst");

        // Randomized bursts with random backpressure and occasional corrupted WLAST.
        rand_ready = 1'b1;
        for (int b = 0; b < 40; b++) begin
            len = $urandom_range(0, 15);
            send_aw(len);
            for (int k = 0; k <= len; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                wl = (k == len);
                if ($urandom_range(0, 7) == 0) wl = !wl;
                push_word(wl);
            end
        end
        drain("drain_random");
        rand_ready = 1'b0;
        WREADY_S = 1'b1;
        repeat (3) tick();
        chk("total_wlast_err", 64'(err_seen), 64'(exp_err));
        chk("fifo_source_empty", 64'(fq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_w_fifo_drain.md
# axi_w_fifo_drain

Read-side drain for the slave-to-write (S_W) asynchronous FIFO. It runs in the slave clock domain. It pops packed write-data words {WDATA, WSTRB, WLAST} out of the FIFO and presents them as an AXI4 W channel to the downstream slave. Beats are released against burst lengths taken from accepted AW handshakes, and WLAST is enforced and checked. A 2-entry output buffer lets the block sustain one beat per cycle with registered outputs.

## Interface
- DATA_W, 32, WDATA width; WSTRB width is DATA_W/8; FIFO word width FW = DATA_W + DATA_W/8 + 1 = 37 by default.
- LEN_W, 4, AW length field width (burst = len+1 beats).
- clk  in  1  slave-domain clock; same clock as the FIFO read side.
- rst  in  1  asynchronous, active-high reset.
- fifo_rdata  in  FW  FIFO read word, packed {WDATA, WSTRB, WLAST}; valid combinationally whenever fifo_rempty=0.
- fifo_rempty  in  1  FIFO empty.
- fifo_rpop  out  1  pop strobe; the FIFO advances on clk when this is 1.
- aw_fire  in  1  AW handshake completed this cycle on the slave side.
- aw_len  in  LEN_W  AWLEN of that handshake.
- aw_room  out  1  length queue can accept an aw_fire this cycle.
- WDATA_S  out  DATA_W  write data to slave.
- WSTRB_S  out  DATA_W/8  write strobes.
- WLAST_S  out  1  last beat of burst.
- WVALID_S  out  1  beat valid.
- WREADY_S  in  1  slave ready.
- wlast_err  out  1  one-cycle pulse on a WLAST mismatch.

## Operation
- Length queue: 2-entry FIFO of LEN_W-bit lengths.
  - Pushed on aw_fire. aw_room = (lq_cnt < 2).
  - aw_fire while aw_room=0 is a protocol violation. The entry is dropped and nothing else changes.
- Fetch stage:
  - beat_cnt (LEN_W bits) counts beats popped in the current burst.
  - fifo_rpop = !fifo_rempty & (lq_cnt != 0) & (buf_cnt < 2).
  - On a pop the beat is written into the output buffer. is_last = (beat_cnt == lq_head).
  - The stored WLAST is forced to is_last.
  - If the FIFO WLAST bit != is_last, wlast_err pulses the next cycle. The beat is still forwarded with the forced value.
  - When is_last is popped, beat_cnt -> 0 and the lq head is retired. Otherwise beat_cnt increments.
  - A new length pushed in the same cycle as a retire is kept. lq_cnt is unchanged in that case.
- Output buffer: 2-entry FIFO with occupancy buf_cnt 0..2.
  - The head drives WDATA_S/WSTRB_S/WLAST_S. WVALID_S = (buf_cnt != 0).
  - A beat is accepted when WVALID_S & WREADY_S, which removes the head.
  - A pop and an accept in the same cycle leave buf_cnt unchanged.
- Once WVALID_S is asserted, the W payload holds stable until accepted (AXI rule).
- The block never pops beyond the number of beats announced by queued lengths.

## Timing
- Reset values:
  - fifo_rpop=0 (combinationally, since buf and lq are empty).
  - WVALID_S=0, WLAST_S=0, WDATA_S=0, WSTRB_S=0.
  - wlast_err=0, aw_room=1, beat_cnt=0, lq_cnt=0, buf_cnt=0.
- Reset asserted mid-burst flushes the buffer and length queue immediately (asynchronous). Any beat being offered is discarded.
- Latency: with FIFO non-empty, a length queued and the buffer empty, fifo_rpop=1 in cycle N and WVALID_S=1 in cycle N+1.
- A length pushed in cycle N is usable for popping in cycle N+1.
- Throughput: 1 beat/cycle with WREADY_S held high.
- Backpressure: with WREADY_S low, at most 2 beats are popped, then fifo_rpop=0.
- No combinational path from WREADY_S to fifo_rpop: the pop decision uses registered buf_cnt.
- Boundaries:
  - len=0 makes a single-beat burst, with WLAST_S=1 on that beat.
  - beat_cnt reaching 2^LEN_W-1 retires the burst and does not wrap into the next burst.
  - Back-to-back bursts run with no bubble.
  - FIFO empty mid-burst gives WVALID_S low after the buffered beats drain; the burst resumes when data arrives.

## Test plan
- Single burst: aw_len=3, FIFO holds 4 words with WLAST on the 4th, WREADY_S=1 -> four beats on consecutive cycles starting 1 cycle after the first pop. WLAST_S=1 only on beat 4; wlast_err never pulses.
- Backpressure: aw_len=7, 8 words, WREADY_S=0 for 5 cycles then 1 -> exactly 2 pops during the stall. The first beat holds stable; all 8 beats arrive in order with no loss or duplicate.
- No length queued: FIFO holds data, aw_fire never asserted -> fifo_rpop stays 0 and WVALID_S stays 0. After aw_fire with aw_len=0, exactly one beat is forwarded with WLAST_S=1.
- WLAST mismatch: aw_len=1 while the FIFO word 2 has WLAST=0 -> beat 2 is sent with WLAST_S=1 and wlast_err pulses once. A following burst (aw_len=0) is unaffected.
- Length queue full: three aw_fire with no FIFO data -> aw_room=0 after the second. Push and retire in the same cycle keep lq_cnt=2.
- Reset mid-burst: assert rst during beat 2 of a 4-beat burst -> WVALID_S=0 immediately and all counters are 0. A new burst after rst deasserts starts at beat 0.
